// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with a clock-enable prescaler, wrap/saturate end mode,
// synchronous preset, terminal-count pulse and hex seven-segment decode of the count.
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int DIV      = 3,
    parameter int MODULUS  = 10,
    parameter int INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             up,
    input  logic             sat,
    input  logic             init,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic [6:0]       seg
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_INIT = WIDTH'(INIT_VAL);

    // Illegal parameter combinations stop elaboration rather than building a broken counter.
    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be 1..16");
        end
        if (DIV < 1) begin : g_bad_div
            $error("updown_mod_counter: DIV must be >= 1");
        end
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must be 2..2**WIDTH");
        end
        if (INIT_VAL < 0 || INIT_VAL >= MODULUS) begin : g_bad_init
            $error("updown_mod_counter: INIT_VAL must be below MODULUS");
        end
    endgenerate

    logic [PW-1:0]    r_pcnt;
    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             w_boundary;
    logic [WIDTH-1:0] w_next_q;
    logic [3:0]       w_nib;

    assign tick = ena & (r_pcnt == P_LAST) & ~init & ~rst;

    // A boundary is reached at the top going up or at zero going down; sat picks hold vs wrap.
    always_comb begin
        w_boundary = up ? (r_q == Q_LAST) : (r_q == '0);
        w_next_q   = r_q;
        if (!w_boundary) begin
            w_next_q = up ? r_q + 1'b1 : r_q - 1'b1;
        end else if (!sat) begin
            w_next_q = up ? '0 : Q_LAST;
        end
    end

    // The prescale phase only moves on enabled edges, so dropping ena never loses phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (init) begin
            r_pcnt <= '0;
        end else if (ena) begin
            r_pcnt <= (r_pcnt == P_LAST) ? '0 : r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= Q_INIT;
            r_tc <= 1'b0;
        end else if (init) begin
            r_q  <= Q_INIT;
            r_tc <= 1'b0;
        end else if (tick) begin
            r_q  <= w_next_q;
            r_tc <= w_boundary;
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign q  = r_q;
    assign tc = r_tc;

    // Narrow counters are zero-extended, wide ones show only their low hex digit.
    assign w_nib = 4'(r_q);

    always_comb begin
        seg = 7'b0000000;
        case (w_nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: directed scenarios plus randomized
// control traffic compared against an arithmetic reference model of the counter.
module tb_updown_mod_counter;

    localparam int WIDTH    = 4;
    localparam int DIV      = 3;
    localparam int MODULUS  = 10;
    localparam int INIT_VAL = 0;

    logic       clk = 1'b0;
    logic       rst, ena, up, sat, init;
    logic [3:0] q;
    logic       tick, tc;
    logic [6:0] seg;

    int   nPass  = 0;
    int   nTotal = 0;
    int   mq;
    int   mph;
    logic mtc;

    updown_mod_counter #(
        .WIDTH(WIDTH), .DIV(DIV), .MODULUS(MODULUS), .INIT_VAL(INIT_VAL)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .up(up), .sat(sat), .init(init),
        .q(q), .tick(tick), .tc(tc), .seg(seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[v % 16];
    endfunction

    function automatic logic model_tick();
        return ena && !init && !rst && (mph == DIV - 1);
    endfunction

    // Advance one rising edge and update the reference model with plain arithmetic.
    task automatic advance();
        logic t;
        bit   bnd;
        t = model_tick();
        @(posedge clk);
        if (rst || init) begin
            mq = INIT_VAL; mph = 0; mtc = 1'b0;
        end else begin
            if (ena) mph = (mph + 1) % DIV;
            if (t) begin
                bnd = up ? (mq == MODULUS - 1) : (mq == 0);
                if (!bnd) mq = up ? mq + 1 : mq - 1;
                else if (!sat) mq = up ? 0 : MODULUS - 1;
                mtc = bnd;
            end else begin
                mtc = 1'b0;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; ena = 1'b0; up = 1'b1; sat = 1'b0; init = 1'b0;
        #12;
        mq = INIT_VAL; mph = 0; mtc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        ena = 1'b1; up = 1'b1;
        repeat (18) advance();
        nTotal++;
        if (q !== 4'd6) $display("[TB] FAIL reset_pre_q: got %0d want 6", q); else nPass++;
        #2 rst = 1'b1;
        #1;
        nTotal++;
        if (q !== 4'd0) $display("[TB] FAIL reset_async_q: got %0d want 0", q); else nPass++;
        nTotal++;
        if (tc !== 1'b0) $display("[TB] FAIL reset_async_tc: got %b want 0", tc); else nPass++;
        nTotal++;
        if (seg !== 7'b0111111) $display("[TB] FAIL reset_async_seg: got %b want 0111111", seg); else nPass++;
        nTotal++;
        if (tick !== 1'b0) $display("[TB] FAIL reset_async_tick: got %b want 0", tick); else nPass++;
        mq = INIT_VAL; mph = 0; mtc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            nTotal++;
            if (tick !== (i == 2)) $display("[TB] FAIL reset_first_tick edge %0d: got %b want %b", i + 1, tick, (i == 2));
            else nPass++;
            advance();
        end
        nTotal++;
        if (q !== 4'd1) $display("[TB] FAIL reset_first_step_q: got %0d want 1", q); else nPass++;
    endtask

    task automatic test_up_wrap();
        apply_reset();
        ena = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            nTotal++;
            if (tick !== (i % 3 == 2)) $display("[TB] FAIL upwrap_tick edge %0d: got %b want %b", i + 1, tick, (i % 3 == 2));
            else nPass++;
            advance();
            if (i == 26) begin
                nTotal++;
                if (q !== 4'd9) $display("[TB] FAIL upwrap_q27: got %0d want 9", q); else nPass++;
            end
        end
        nTotal++;
        if (q !== 4'd0 || tc !== 1'b1) $display("[TB] FAIL upwrap_wrap: got q=%0d tc=%b want q=0 tc=1", q, tc);
        else nPass++;
        advance();
        nTotal++;
        if (tc !== 1'b0) $display("[TB] FAIL upwrap_tc_one_cycle: got %b want 0", tc); else nPass++;
    endtask

    task automatic test_down_wrap();
        apply_reset();
        ena = 1'b1; up = 1'b0; sat = 1'b0;
        repeat (3) advance();
        nTotal++;
        if (q !== 4'd9 || tc !== 1'b1) $display("[TB] FAIL downwrap: got q=%0d tc=%b want q=9 tc=1", q, tc);
        else nPass++;
        nTotal++;
        if (seg !== 7'b1101111) $display("[TB] FAIL downwrap_seg: got %b want 1101111", seg); else nPass++;
        advance();
        nTotal++;
        if (tc !== 1'b0) $display("[TB] FAIL downwrap_tc_one_cycle: got %b want 0", tc); else nPass++;
    endtask

    task automatic test_saturate();
        int   ticks = 0;
        logic t;
        up = 1'b1; sat = 1'b1; ena = 1'b1;
        for (int i = 0; i < 20 && ticks < 4; i++) begin
            t = model_tick();
            if (t) ticks++;
            advance();
            nTotal++;
            if (q !== 4'd9 || tc !== t) $display("[TB] FAIL sat_hold edge %0d: got q=%0d tc=%b want q=9 tc=%b", i, q, tc, t);
            else nPass++;
        end
        nTotal++;
        if (ticks != 4) $display("[TB] FAIL sat_tick_count: got %0d want 4", ticks); else nPass++;
        up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t = model_tick();
            advance();
            if (t) break;
        end
        nTotal++;
        if (q !== 4'd8 || tc !== 1'b0) $display("[TB] FAIL sat_down: got q=%0d tc=%b want q=8 tc=0", q, tc);
        else nPass++;
    endtask

    task automatic test_init_priority();
        apply_reset();
        ena = 1'b1; up = 1'b1; sat = 1'b0;
        repeat (14) advance();
        nTotal++;
        if (q !== 4'd4) $display("[TB] FAIL init_pre_q: got %0d want 4", q); else nPass++;
        init = 1'b1;
        #1;
        nTotal++;
        if (tick !== 1'b0) $display("[TB] FAIL init_tick_suppressed: got %b want 0", tick); else nPass++;
        advance();
        init = 1'b0;
        nTotal++;
        if (q !== 4'd0 || tc !== 1'b0) $display("[TB] FAIL init_load: got q=%0d tc=%b want q=0 tc=0", q, tc);
        else nPass++;
        for (int i = 0; i < 3; i++) begin
            #1;
            nTotal++;
            if (tick !== (i == 2)) $display("[TB] FAIL init_next_tick edge %0d: got %b want %b", i + 1, tick, (i == 2));
            else nPass++;
            advance();
        end
        nTotal++;
        if (q !== 4'd1) $display("[TB] FAIL init_after_q: got %0d want 1", q); else nPass++;
    endtask

    task automatic test_ena_gating();
        apply_reset();
        ena = 1'b1; up = 1'b1; sat = 1'b0;
        repeat (2) advance();
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            nTotal++;
            if (tick !== 1'b0 || q !== 4'd0) $display("[TB] FAIL ena_frozen cycle %0d: got tick=%b q=%0d want tick=0 q=0", i, tick, q);
            else nPass++;
            advance();
        end
        ena = 1'b1;
        #1;
        nTotal++;
        if (tick !== 1'b1) $display("[TB] FAIL ena_resume_tick: got %b want 1", tick); else nPass++;
        advance();
        nTotal++;
        if (q !== 4'd1 || tc !== 1'b0) $display("[TB] FAIL ena_resume_q: got q=%0d tc=%b want q=1 tc=0", q, tc);
        else nPass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            ena  = ($urandom_range(0, 9) < 7);
            up   = 1'($urandom_range(0, 1));
            sat  = 1'($urandom_range(0, 1));
            init = ($urandom_range(0, 19) == 0);
            #1;
            nTotal++;
            if (tick !== model_tick()) $display("[TB] FAIL rand_tick cycle %0d: got %b want %b", i, tick, model_tick());
            else nPass++;
            advance();
            nTotal++;
            if (q !== 4'(mq) || tc !== mtc || seg !== glyph(mq))
                $display("[TB] FAIL rand_state cycle %0d: got q=%0d tc=%b seg=%b want q=%0d tc=%b seg=%b",
                         i, q, tc, seg, mq, mtc, glyph(mq));
            else nPass++;
        end
        init = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; up = 1'b1; sat = 1'b0; init = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_init_priority();
        test_ena_gating();
        test_random();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter with a built-in clock-enable prescaler, wrap/saturate mode, synchronous preset, terminal-count pulse and hex seven-segment output. It is the general-purpose successor to the fixed 3-bit sequence counter driven by a divide-by-3 enable. It sits between the board clock and a seven-segment display, or feeds other blocks through `tick` and `tc`.

## Interface
- `WIDTH`, 4: counter width in bits, 1..16.
- `DIV`, 3: prescaler ratio, ≥1. The counter steps once per `DIV` enabled cycles.
- `MODULUS`, 10: count range is 0..`MODULUS`-1. Must satisfy 2 ≤ `MODULUS` ≤ 2^`WIDTH`; any other value is an elaboration error.
- `INIT_VAL`, 0: value loaded by reset and by `init`. Must be < `MODULUS`; any other value is an elaboration error.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ena` in 1: enable; gates both the prescaler and the counter.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `sat` in 1: end mode; 1 = saturate at the range ends, 0 = wrap around.
- `init` in 1: synchronous preset; highest priority after `rst`.
- `q` out `WIDTH`: current count, registered.
- `tick` out 1: prescaler strobe, combinational.
- `tc` out 1: terminal-count pulse, registered.
- `seg` out 7: hex decode of `q`, active-high, combinational. Bit mapping: `seg[0]`=a, `seg[1]`=b, `seg[2]`=c, `seg[3]`=d, `seg[4]`=e, `seg[5]`=f, `seg[6]`=g.

## Operation
- **Prescaler**
  - Internal counter `pcnt` runs 0..`DIV`-1 and advances only while `ena`=1.
  - `pcnt` wraps to 0 after `DIV`-1.
  - `pcnt` holds its value while `ena`=0.
- **tick**
  - `tick` = `ena` & (`pcnt`==`DIV`-1) & ~`init` & ~`rst`.
  - With `DIV`=1, `tick` = `ena` & ~`init` & ~`rst`.
- **Counter step** (only on a clock edge where `tick`=1):
  - `up`=1, `q`<`MODULUS`-1: `q`+1.
  - `up`=1, `q`==`MODULUS`-1: `q` becomes 0 if `sat`=0; `q` holds if `sat`=1.
  - `up`=0, `q`>0: `q`-1.
  - `up`=0, `q`==0: `q` becomes `MODULUS`-1 if `sat`=0; `q` holds if `sat`=1.
- **Terminal count**
  - A boundary event is any tick edge taken while `q` sits at the end of the range in the current direction.
  - This covers both a wrap and a saturated hold.
  - `tc`=1 for exactly one cycle after each boundary event; otherwise `tc`=0.
- **init**
  - `init`=1 on an edge forces `q`=`INIT_VAL`, `pcnt`=0 and `tc`=0.
  - No step occurs on that edge, regardless of `ena`, `up` or `sat`.
- **Control inputs**
  - `up` and `sat` are sampled only on tick edges.
  - Changing them between ticks has no other effect.
- **Seven-segment decode**
  - `seg` decodes `q[3:0]`; if `WIDTH`<4, `q` is zero-extended first.
  - Digits 0-9, A, b, C, d, E, F use the standard hex glyphs.
  - Encodings written as `seg[6:0]`:
    - 0 = 0111111
    - 1 = 0000110
    - 5 = 1101101
    - 9 = 1101111
    - A = 1110111
    - F = 1110001

## Timing
- **Reset** (asynchronous, immediate on `rst` assertion, independent of `clk`):
  - `q`=`INIT_VAL`, `pcnt`=0, `tc`=0, `tick`=0.
  - `seg` shows the glyph for `INIT_VAL`.
- **Mid-operation reset:** an in-progress prescale is discarded. After release, the first `tick` occurs on the `DIV`-th enabled edge.
- **Step latency:** `q` takes its new value on the same edge where `tick`=1 and is visible in the following cycle. `seg` follows `q` combinationally.
- **Terminal count:** `tc` rises in the cycle after the boundary tick edge, i.e. in the same cycle `q` shows the wrapped or held value.
- **Tick spacing:** with `ena` held high, consecutive ticks are exactly `DIV` cycles apart.
- **ena deassertion:** dropping `ena` freezes the prescale phase, so no phase is lost. Example with `DIV`=3: two enabled cycles, `ena` low for N cycles, then the tick arrives on the 3rd enabled edge.
- **init and tick in the same cycle:** `init` wins, and that `tick` is suppressed.
- **rst and init together:** `rst` wins.

## Test plan
All scenarios use `DIV`=3, `MODULUS`=10, `INIT_VAL`=0, `WIDTH`=4.

- **Reset:** assert `rst` asynchronously at `q`=6 -> `q`=0, `tc`=0 and `seg`=0111111 before the next `clk` edge; after release, first `tick` on the 3rd edge.
- **Up wrap:** `ena`=1, `up`=1, `sat`=0 from `q`=0 -> `tick` on every 3rd edge; `q`=9 after 27 edges; `q`=0 with `tc`=1 for one cycle after 30 edges.
- **Down wrap:** `q`=0, `up`=0, `sat`=0 -> after the next tick `q`=9, `tc` pulses once, `seg`=1101111.
- **Saturate:** `q`=9, `up`=1, `sat`=1 for 4 ticks -> `q` stays 9 and `tc` pulses once per tick; then `up`=0 -> `q`=8 on the next tick with no `tc`.
- **init priority:** assert `init` in the cycle where `tick` would fire at `q`=4 -> `q`=0, `pcnt`=0, `tc`=0, no step; next tick 3 enabled edges later.
- **ena gating:** `ena`=1 for 2 edges, 0 for 5 edges, then 1 -> `q` unchanged while `ena`=0; `tick` on the first edge after re-enable; `q` increments by 1.
